// File: rtl/ky32_irq_ctrl.sv
// KY32 eight-line interrupt controller: edge/level request latching, masking,
// priority selection with in-service preemption, and a req/ack handshake to the core.

module KY32_encoder8x3 (
    input  logic [7:0] req,
    output logic [2:0] code,
    output logic       any
);
    // Ascending scan so the highest set index is the last one written.
    always_comb begin
        code = 3'd0;
        any  = |req;
        for (int i = 0; i < 8; i++) begin
            if (req[i]) begin
                code = i[2:0];
            end
        end
    end
endmodule

module ky32_irq_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] irq_in,
    input  logic       cfg_we,
    input  logic [1:0] cfg_addr,
    input  logic [7:0] cfg_wdata,
    output logic [7:0] cfg_rdata,
    output logic       irq_req,
    output logic [2:0] irq_vec,
    input  logic       irq_ack,
    input  logic       eoi
);
    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    state_t     state, state_next;
    logic [7:0] mask, mode, pend, insv, hist;
    logic [7:0] cand, pend_next, insv_next;
    logic [7:0] ack_bit, eoi_bit, wr_clr, edge_set, edge_kept;
    logic [2:0] win, top, vec_next;
    logic       cand_any, insv_any, eligible, ack_fire, req_next;

    KY32_encoder8x3 u_win_enc (
        .req  (cand),
        .code (win),
        .any  (cand_any)
    );

    KY32_encoder8x3 u_top_enc (
        .req  (insv),
        .code (top),
        .any  (insv_any)
    );

    assign cand     = pend & mask;
    assign eligible = cand_any && (!insv_any || (win > top));
    assign ack_fire = (state == REQ) && irq_ack;

    // Edge set is applied last so it beats an ack or write-1 clear in the same cycle.
    always_comb begin
        ack_bit   = ack_fire ? (8'd1 << irq_vec) : 8'd0;
        eoi_bit   = (eoi && insv_any) ? (8'd1 << top) : 8'd0;
        wr_clr    = (cfg_we && cfg_addr == 2'd2) ? cfg_wdata : 8'd0;
        edge_set  = irq_in & ~hist;
        edge_kept = (pend & ~(ack_bit | wr_clr)) | edge_set;
        pend_next = (mode & edge_kept) | (~mode & irq_in);
        insv_next = (insv & ~eoi_bit) | ack_bit;
    end

    always_comb begin
        state_next = state;
        req_next   = irq_req;
        vec_next   = irq_vec;
        case (state)
            IDLE: begin
                req_next = 1'b0;
                if (eligible) begin
                    state_next = REQ;
                    req_next   = 1'b1;
                    vec_next   = win;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    state_next = IDLE;
                    req_next   = 1'b0;
                end else if (eligible) begin
                    vec_next = win;
                end else begin
                    state_next = IDLE;
                    req_next   = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                req_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mask    <= 8'h00;
            mode    <= 8'h00;
            pend    <= 8'h00;
            insv    <= 8'h00;
            hist    <= 8'hFF;
            irq_req <= 1'b0;
            irq_vec <= 3'd0;
        end else begin
            state   <= state_next;
            pend    <= pend_next;
            insv    <= insv_next;
            hist    <= irq_in;
            irq_req <= req_next;
            irq_vec <= vec_next;
            if (cfg_we && cfg_addr == 2'd0) begin
                mask <= cfg_wdata;
            end
            if (cfg_we && cfg_addr == 2'd1) begin
                mode <= cfg_wdata;
            end
        end
    end

    always_comb begin
        case (cfg_addr)
            2'd0:    cfg_rdata = mask;
            2'd1:    cfg_rdata = mode;
            2'd2:    cfg_rdata = pend;
            default: cfg_rdata = insv;
        endcase
    end
endmodule

// File: tb/tb_ky32_irq_ctrl.sv
// Scoreboard bench for ky32_irq_ctrl: a line-by-line behavioural model predicts
// req/vec/readback each cycle; a negedge monitor pops and compares.

module tb_ky32_irq_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irq_in;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic [7:0] cfg_rdata;
    logic       irq_req;
    logic [2:0] irq_vec;
    logic       irq_ack;
    logic       eoi;

    always #5 clk = ~clk;

    ky32_irq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .irq_in    (irq_in),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .irq_req   (irq_req),
        .irq_vec   (irq_vec),
        .irq_ack   (irq_ack),
        .eoi       (eoi)
    );

    typedef struct {
        bit       req;
        bit [2:0] vec;
        bit [7:0] rdata;
        string    name;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Reference state: what the controller should hold after the last edge.
    bit [7:0] m_mask, m_mode, m_pend, m_insv, m_hist;
    bit       m_req;
    int       m_vec;

    // Pending directed expectation for the next cycle.
    bit       spot_on = 0;
    string    spot_name;
    bit [7:0] spot_rd;
    bit       spot_req;
    bit [2:0] spot_vec;

    function automatic int highest(input bit [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit [7:0] model_rd(input bit [1:0] a);
        case (a)
            2'd0:    return m_mask;
            2'd1:    return m_mode;
            2'd2:    return m_pend;
            default: return m_insv;
        endcase
    endfunction

    task automatic model_step(input bit r, input bit [7:0] in, input bit we, input bit [1:0] a,
                              input bit [7:0] wd, input bit ak, input bit eo);
        int       w, t;
        bit       acked;
        bit [7:0] np, ni;
        if (r) begin
            m_mask = 0; m_mode = 0; m_pend = 0; m_insv = 0;
            m_hist = 8'hFF; m_req = 0; m_vec = 0;
            return;
        end
        w     = highest(m_pend & m_mask);
        t     = highest(m_insv);
        acked = m_req && ak;
        for (int i = 0; i < 8; i++) begin
            if (m_mode[i]) begin
                np[i] = m_pend[i];
                if (acked && m_vec == i) np[i] = 0;
                if (we && a == 2'd2 && wd[i]) np[i] = 0;
                if (in[i] && !m_hist[i]) np[i] = 1;
            end else begin
                np[i] = in[i];
            end
        end
        ni = m_insv;
        if (eo && t >= 0) ni[t] = 0;
        if (acked) ni[m_vec] = 1;
        if (acked) m_req = 0;
        else if (w >= 0 && w > t) begin
            m_req = 1;
            m_vec = w;
        end else m_req = 0;
        if (we && a == 2'd0) m_mask = wd;
        if (we && a == 2'd1) m_mode = wd;
        m_pend = np;
        m_insv = ni;
        m_hist = in;
    endtask

    task automatic spot(input string nm, input bit [7:0] rd, input bit rq, input bit [2:0] vc);
        spot_on   = 1;
        spot_name = nm;
        spot_rd   = rd;
        spot_req  = rq;
        spot_vec  = vc;
    endtask

    task automatic drive_cycle(input bit r, input bit [7:0] in, input bit we, input bit [1:0] a,
                               input bit [7:0] wd, input bit ak, input bit eo, input bit push);
        exp_t e;
        rst = r; irq_in = in; cfg_we = we; cfg_addr = a; cfg_wdata = wd;
        irq_ack = ak; eoi = eo;
        if (push) begin
            if (spot_on) begin
                e.req = spot_req; e.vec = spot_vec; e.rdata = spot_rd; e.name = spot_name;
                spot_on = 0;
            end else begin
                e.req = m_req; e.vec = 3'(m_vec); e.rdata = model_rd(a); e.name = "model";
            end
            sb.push_back(e);
        end
        @(posedge clk);
        model_step(r, in, we, a, wd, ak, eo);
        #1;
    endtask

    task automatic st(input bit [7:0] in, input bit [1:0] a, input bit ak, input bit eo);
        drive_cycle(0, in, 0, a, 8'h00, ak, eo, 1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            tests++;
            if ({irq_req, irq_vec, cfg_rdata} !== {e.req, e.vec, e.rdata}) begin
                fails++;
                $display("FAIL %s addr=%0d: got req=%b vec=%0d rdata=%h, want req=%b vec=%0d rdata=%h",
                         e.name, cfg_addr, irq_req, irq_vec, cfg_rdata, e.req, e.vec, e.rdata);
            end
        end
    end

    initial begin
        bit [7:0] rin;
        bit       we, ak, eo, r;
        bit [1:0] a;
        bit [7:0] wd;

        rst = 1; irq_in = 8'hFF; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0; irq_ack = 0; eoi = 0;
        m_mask = 0; m_mode = 0; m_pend = 0; m_insv = 0; m_hist = 8'hFF; m_req = 0; m_vec = 0;

        // Reset with all lines high
        drive_cycle(1, 8'hFF, 0, 0, 8'h00, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            spot("reset_state", 8'h00, 0, 0);
            drive_cycle(1, 8'hFF, 0, 2'(k), 8'h00, 0, 0, 1);
        end
        drive_cycle(0, 8'hFF, 1, 1, 8'hFF, 0, 0, 1);
        drive_cycle(0, 8'hFF, 1, 2, 8'hFF, 0, 0, 1);
        drive_cycle(0, 8'hFF, 1, 0, 8'hFF, 0, 0, 1);
        spot("hold_pend", 8'h00, 0, 0);      st(8'h00, 2, 0, 0);
        st(8'h01, 2, 0, 0);
        spot("edge_pend", 8'h01, 0, 0);      st(8'h01, 2, 0, 0);
        spot("first_req", 8'h00, 1, 0);      st(8'h00, 3, 1, 0);
        spot("ack_insv", 8'h01, 0, 0);       st(8'h00, 3, 0, 1);
        st(8'h00, 3, 0, 0);

        // Priority
        st(8'h24, 2, 0, 0);
        st(8'h00, 2, 0, 0);
        spot("prio_hi", 8'h24, 1, 5);        st(8'h00, 2, 1, 0);
        spot("prio_ack", 8'h20, 0, 5);       st(8'h00, 3, 0, 1);
        st(8'h00, 2, 0, 0);
        spot("prio_lo", 8'h04, 1, 2);        st(8'h00, 2, 1, 0);
        st(8'h00, 3, 0, 1);

        // Preemption
        st(8'h08, 2, 0, 0);
        st(8'h00, 2, 0, 0);
        st(8'h00, 2, 1, 0);
        spot("pre_insv", 8'h08, 0, 3);       st(8'h02, 3, 0, 0);
        st(8'h00, 2, 0, 0);
        spot("low_blocked", 8'h02, 0, 3);    st(8'h00, 2, 0, 0);
        st(8'h00, 2, 0, 0);
        st(8'h00, 2, 0, 0);
        st(8'h40, 2, 0, 0);
        st(8'h00, 2, 0, 0);
        spot("pre_req6", 8'h42, 1, 6);       st(8'h00, 2, 1, 0);
        spot("pre_insv48", 8'h48, 0, 6);     st(8'h00, 3, 0, 1);
        spot("pre_eoi1", 8'h08, 0, 6);       st(8'h00, 3, 0, 1);
        st(8'h00, 2, 0, 0);
        st(8'h00, 2, 1, 0);
        st(8'h00, 3, 0, 1);

        // Vector replacement
        st(8'h04, 2, 0, 0);
        st(8'h00, 2, 0, 0);
        st(8'h80, 2, 0, 0);
        spot("repl_before", 8'h84, 1, 2);    st(8'h00, 2, 0, 0);
        spot("repl_vec7", 8'h84, 1, 7);      st(8'h00, 2, 1, 0);
        spot("repl_insv", 8'h80, 0, 7);      st(8'h00, 3, 0, 0);
        spot("repl_pend2", 8'h04, 0, 7);     st(8'h00, 2, 0, 1);
        st(8'h00, 2, 0, 0);
        st(8'h00, 2, 1, 0);
        st(8'h00, 3, 0, 1);

        // Level withdrawal on line 4
        drive_cycle(0, 8'h00, 1, 1, 8'hEF, 0, 0, 1);
        st(8'h10, 2, 0, 0);
        st(8'h10, 2, 0, 0);
        spot("lvl_req", 8'h10, 1, 4);        st(8'h00, 2, 0, 0);
        spot("lvl_pend0", 8'h00, 1, 4);      st(8'h00, 2, 0, 0);
        spot("lvl_wd", 8'h00, 0, 4);         st(8'h00, 3, 0, 0);
        drive_cycle(0, 8'h00, 1, 1, 8'hFF, 0, 0, 1);

        // Re-edge in the ack cycle
        st(8'h01, 2, 0, 0);
        st(8'h00, 2, 0, 0);
        st(8'h01, 2, 1, 0);
        spot("sim_pend", 8'h01, 0, 0);       st(8'h01, 2, 0, 0);
        st(8'h00, 3, 0, 1);
        st(8'h00, 2, 0, 0);
        st(8'h00, 2, 1, 0);
        st(8'h00, 3, 0, 1);

        // EOI and ack together
        st(8'h04, 2, 0, 0);
        st(8'h00, 2, 0, 0);
        st(8'h00, 2, 1, 0);
        st(8'h40, 2, 0, 0);
        st(8'h00, 2, 0, 0);
        spot("ee_req6", 8'h04, 1, 6);        st(8'h00, 3, 1, 1);
        spot("ee_insv", 8'h40, 0, 6);        st(8'h00, 3, 0, 1);

        // PEND write-1 against a same-cycle edge, then write-clear withdrawal
        drive_cycle(0, 8'h02, 1, 2, 8'h02, 0, 0, 1);
        spot("wr_vs_edge", 8'h02, 0, 6);     st(8'h02, 2, 0, 0);
        drive_cycle(0, 8'h00, 1, 2, 8'h02, 0, 0, 1);
        st(8'h00, 2, 0, 0);
        spot("wr_withdraw", 8'h00, 0, 1);    st(8'h00, 3, 0, 0);

        // Randomized traffic, with one reset in the middle
        rin = 8'h00;
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(7) == 0) rin[b] = ~rin[b];
            end
            r  = (i == 700);
            we = ($urandom_range(5) == 0);
            a  = 2'($urandom_range(3));
            wd = 8'($urandom);
            if (we && a == 2'd0) wd = wd | 8'($urandom);
            ak = m_req ? ($urandom_range(2) == 0) : ($urandom_range(15) == 0);
            eo = ($urandom_range(7) == 0);
            drive_cycle(r, rin, we, a, wd, ak, eo, 1);
        end

        @(posedge clk);
        #1;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ky32_irq_ctrl.md
# ky32_irq_ctrl

Eight-line interrupt controller for the KY32 core. Latches edge- or level-sensitive requests and masks them. Selects the highest-numbered eligible line with the 8-to-3 priority encoder (`KY32_encoder8x3`) and presents it to the core over a req/ack handshake. Tracks in-service levels so that only strictly higher-priority lines can preempt; the core reads and writes configuration through a small register port.

## Interface
- No parameters; line count fixed at 8, vector width 3.
- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `irq_in`  in  8  raw interrupt lines, bit i = line i, synchronous to `clk`
- `cfg_we`  in  1  register write strobe
- `cfg_addr`  in  2  register select: 0 MASK, 1 MODE, 2 PEND, 3 INSV
- `cfg_wdata`  in  8  write data
- `cfg_rdata`  out  8  combinational read of selected register
- `irq_req`  out  1  interrupt request to core (registered)
- `irq_vec`  out  3  vector of requested line (registered), valid while `irq_req`=1
- `irq_ack`  in  1  core accepts the vector currently on `irq_vec`
- `eoi`  in  1  one-cycle end-of-interrupt pulse

## Operation
- Registers:
  - MASK: 1 = line enabled.
  - MODE: 1 = edge, 0 = level.
  - PEND:
    - Read returns pending bits.
    - Write-1-to-clear affects edge lines only; zeros and level bits are ignored.
  - INSV: in-service bits; read-only, writes ignored.
- Reset values: MASK=0, MODE=0, PEND=0, INSV=0, edge-history register=8'hFF, state=IDLE, `irq_req`=0, `irq_vec`=0.
  - Because history resets to 1s, a line held high through reset does not register an edge.
- Pending update, every cycle, per line:
  - Edge lines: set on `irq_in & ~hist`. Clear by ack of that vector or by PEND write-1. Set wins over a simultaneous clear.
  - Level lines: PEND bit <= `irq_in` bit.
  - `hist` <= `irq_in` every cycle.
  - Pending accumulates regardless of MASK.
- Eligibility, combinational:
  - `cand` = PEND & MASK.
  - `win` = priority encode of `cand`; highest index wins.
  - `top` = priority encode of INSV.
  - Eligible when `|cand` and (INSV==0 or `win` > `top`).
  - An equal-or-lower line than the current in-service one never requests.
- State machine:
  - IDLE:
    - `irq_req`=0.
    - If eligible: go to REQ, `irq_vec` <= `win`, `irq_req` <= 1.
  - REQ, with `irq_ack`=1:
    - INSV[`irq_vec`] <= 1.
    - If that line is edge mode, clear its PEND bit.
    - `irq_req` <= 0, go to IDLE.
  - REQ, with `irq_ack`=0:
    - If eligible: `irq_vec` <= `win`. A higher line arriving replaces the vector; `irq_req` stays 1.
    - If not eligible: withdraw, `irq_req` <= 0, go to IDLE. Covers masked, level dropped, or PEND cleared by write.
  - An ack in IDLE is ignored.
- `eoi`:
  - Clears the highest set INSV bit, as seen at cycle start.
  - With INSV=0 it is a no-op.
  - `eoi` and ack in the same cycle: the clear uses the old INSV and the ack's set is applied at the same edge; both take effect.
- Config write and ack in the same cycle: both apply. The PEND write clear never overrides an edge set in the same cycle.

## Timing
- `irq_in` edge seen at edge N -> PEND set after edge N.
- Eligible in cycle N+1 -> `irq_req`/`irq_vec` high after edge N+1. Minimum latency: 2 cycles from line change to request.
- Ack at edge M -> `irq_req` low after M. Re-request is possible at the earliest 1 cycle later: IDLE lasts at least one cycle between requests.
- `irq_vec` changes only on clock edges. Ack always refers to the `irq_vec` value visible during the ack cycle.
- MASK write at edge M affects eligibility from cycle M+1.
- `rst` mid-handshake returns every register to its reset value at that edge. A pending ack in the reset cycle is discarded.
- `cfg_rdata` is combinational from registers; a write becomes visible on the next cycle.

## Test plan
- Reset then idle:
  - Stimulus: `irq_in`=8'hFF held through reset, MASK=FF, MODE=FF.
  - Required: PEND stays 0 and `irq_req` stays 0. After `irq_in`->00->01: PEND=01 after 1 edge, `irq_req`=1 and `irq_vec`=0 after 2 edges.
- Priority:
  - Stimulus: lines 2 and 5 pending, both masked on.
  - Required: `irq_vec`=5. After ack and EOI, `irq_vec`=2 is requested next.
- Preemption:
  - Stimulus: ack line 3 (INSV=08), then raise line 1, then raise line 6.
  - Required: line 1 never requests. Line 6 requests `irq_vec`=6; after ack INSV=48; first EOI leaves INSV=08.
- Vector replacement:
  - Stimulus: `irq_req` with vector 2 unacked, then line 7 pends.
  - Required: `irq_vec`=7 next cycle with `irq_req` held. Ack -> INSV=80, line 2 still pending.
- Level withdrawal:
  - Stimulus: level line 4 requesting, `irq_in[4]` drops before ack.
  - Required: PEND[4]=0 next edge, `irq_req`=0 the edge after, INSV unchanged.
- Simultaneous events:
  - Stimulus: edge line 0 re-edges in the same cycle as its ack.
  - Required: PEND[0] remains 1.
  - Stimulus: `eoi`+ack in one cycle with INSV=04 and vector 6.
  - Required: INSV=40.
